alu_op_sequencer: RTL

Issue-side front end for the 16-bit CPU ALU. It accepts operation requests (op, operand A, operand B) over a valid/ready handshake and buffers them in a small in-order FIFO. It drives the combinational ALU's `ALUop`/`srcA`/`srcB` inputs from the FIFO head, registers `ALUresult` together with zero/negative flags, and presents it on a valid/ready response port. It sits between the decode/operand-fetch stage and writeback, and isolates the ALU from upstream and downstream stalls.

---
 rtl/alu_op_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue-side front end for the 16-bit ALU.
// Buffers (op, A, B) requests in an in-order FIFO, drives the combinational
// ALU from the FIFO head, and registers the ALU result with zero/negative
// flags on a valid/ready response port.
module alu_op_sequencer #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4      // power of two, >= 2
) (
    input  logic         clk,
    input  logic         rst,

    // request port
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,

    // ALU drive / result
    output logic [1:0]   alu_op,
    output logic [W-1:0] alu_src_a,
    output logic [W-1:0] alu_src_b,
    input  logic [W-1:0] alu_result,

    // response port
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [1:0]   rsp_op,
    output logic         rsp_zero,
    output logic         rsp_neg
);

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    req_t            mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            rsp_valid_q,  rsp_valid_d;
    logic [W-1:0]    rsp_result_q, rsp_result_d;
    logic [1:0]      rsp_op_q,     rsp_op_d;
    logic            rsp_zero_q,   rsp_zero_d;
    logic            rsp_neg_q,    rsp_neg_d;

    logic            fifo_empty;
    logic            push;
    logic            issue;
    req_t            head;

    // Handshake qualifiers; req_ready comes from registered count only.
    assign fifo_empty = (count_q == '0);
    assign req_ready  = (count_q < CW'(DEPTH));
    assign push       = req_valid && req_ready;
    assign issue      = !fifo_empty && (!rsp_valid_q || rsp_ready);
    assign head       = mem_q[rd_ptr_q];

    // ALU drive from the FIFO head; forced to zero while the FIFO is empty.
    always_comb begin
        alu_op    = 2'b00;
        alu_src_a = '0;
        alu_src_b = '0;
        if (!fifo_empty) begin
            alu_op    = head.op;
            alu_src_a = head.a;
            alu_src_b = head.b;
        end
    end

    // Next-state for pointers, occupancy and the response register.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_neg_d    = rsp_neg_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (issue) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_op_d     = head.op;
            rsp_zero_d   = (alu_result == '0);
            rsp_neg_d    = alu_result[W-1];
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end

        case ({push, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and response state; cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= 2'b00;
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_neg_q    <= rsp_neg_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_t'{op: req_op, a: req_a, b: req_b};
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_neg    = rsp_neg_q;

endmodule
